im_loader: RTL and testbench

- Boot-time writer for the instruction memory: receives a byte stream from a host link and writes 32-bit words into the IM write port.
- Uses the same byte address map the fetch side uses for reads: base 0x0000_3000, word index = (addr - base)[13:2].
- Loads either the main program region or the exception-handler region, and verifies each packet with an XOR checksum.
- Holds the CPU in reset until a main program has loaded successfully.

---
 rtl/im_loader_if.sv | 24 ++
 rtl/im_loader.sv | 177 +++++++++++++++++
 tb/tb_im_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// Host byte stream, IM write port and loader status, bundled for the im_loader boundary.
// The master side is the loader itself; the slave side is the host/IM/CPU environment.
interface im_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_hold;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_hold
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, im_we, im_addr, im_wdata, busy, done, err, cpu_hold
    );
endinterface

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses CMD/LEN/data/CSUM packets from a byte stream,
// writes 32-bit words into the IM and holds the CPU in reset until a main program loads.
module im_loader #(
    parameter logic [31:0] BASE_ADDR     = 32'h0000_3000,
    parameter int unsigned MAIN_WORDS    = 1120,
    parameter int unsigned HANDLER_BASE  = 1120,
    parameter int unsigned HANDLER_WORDS = 928
) (
    input logic         clk,
    input logic         reset,
    im_loader_if.master bus
);

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StCsum
    } state_e;

    state_e      state_q, state_d;
    logic        handler_q, handler_d;  // 1: handler region, 0: main region
    logic [7:0]  len_hi_q, len_hi_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [11:0] idx_q, idx_d;
    logic [10:0] remain_q, remain_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;

    logic        accept;
    logic        busy;
    logic [15:0] len;
    logic [15:0] limit;
    logic [11:0] start;

    assign busy   = (state_q != StIdle);
    assign accept = bus.rx_valid && (state_q != StWrite);
    assign len    = {len_hi_q, bus.rx_data};
    assign limit  = handler_q ? 16'(HANDLER_WORDS) : 16'(MAIN_WORDS);
    assign start  = handler_q ? 12'(HANDLER_BASE) : 12'd0;

    always_comb begin
        state_d    = state_q;
        handler_d  = handler_q;
        len_hi_d   = len_hi_q;
        csum_d     = csum_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        idx_d      = idx_q;
        remain_d   = remain_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        err_d      = err_q;
        hold_d     = hold_q;

        // Release the CPU the cycle after a successful main-region load reports done.
        if (done_q && !handler_q) begin
            hold_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
                        handler_d = (bus.rx_data == 8'h02);
                        err_d     = 1'b0;
                        csum_d    = 8'h00;
                        state_d   = StLenHi;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = bus.rx_data;
                    csum_d   = csum_q ^ bus.rx_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    csum_d = csum_q ^ bus.rx_data;
                    if (len > limit) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else if (len == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        idx_d      = start;
                        remain_d   = len[10:0];
                        byte_cnt_d = 2'd0;
                        state_d    = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d     = csum_q ^ bus.rx_data;
                    word_d     = {word_q[15:0], bus.rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {word_q, bus.rx_data};
                        addr_d  = BASE_ADDR + {18'd0, idx_q, 2'b00};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                idx_d    = idx_q + 12'd1;
                remain_d = remain_q - 11'd1;
                state_d  = (remain_q == 11'd1) ? StCsum : StData;
            end
            StCsum: begin
                if (accept) begin
                    if (bus.rx_data == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            handler_q  <= 1'b0;
            len_hi_q   <= 8'h00;
            csum_q     <= 8'h00;
            word_q     <= 24'h0;
            byte_cnt_q <= 2'd0;
            idx_q      <= 12'd0;
            remain_q   <= 11'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            handler_q  <= handler_d;
            len_hi_q   <= len_hi_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            idx_q      <= idx_d;
            remain_q   <= remain_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.rx_ready = (state_q != StWrite);
    assign bus.im_we    = we_q;
    assign bus.im_addr  = addr_q;
    assign bus.im_wdata = wdata_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cpu_hold = hold_q | busy;

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: directed packets from the load procedure plus random packets,
// checked against a packet-level model of expected IM writes, done, err and cpu_hold.
module tb_im_loader;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          MAINW = 1120;
    localparam int          HBASE = 1120;
    localparam int          HW    = 928;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    im_loader_if bus ();

    im_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_n = 0;
    wr_t wr_q[$];
    int rdy_low_q[$];

    // Observe on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (bus.im_we) wr_q.push_back('{bus.im_addr, bus.im_wdata, cyc});
        if (!bus.rx_ready) rdy_low_q.push_back(cyc);
        if (bus.done) done_n++;
    end

    logic [7:0]  pkt[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          hold_m = 1'b1;
    bit          err_m = 1'b0;
    int          wr_base, done_base, rdy_base;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                @(posedge clk);
                #1;
                bus.rx_valid = 1'b0;
                return;
            end
        end
        check_eq("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_range(input int from, input int max_gap);
        for (int i = from; i < pkt.size(); i++) begin
            send_byte(pkt[i]);
            if (max_gap > 0 && i != pkt.size() - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    // Packet-level model: expected writes follow directly from region start and data order.
    task automatic make_pkt(input logic [7:0] cmd, input int n, input bit bad_csum);
        logic [7:0]  x;
        logic [31:0] w;
        int          start;
        pkt.delete();
        exp_addr.delete();
        exp_data.delete();
        start = (cmd == 8'h02) ? HBASE : 0;
        pkt.push_back(cmd);
        pkt.push_back(8'(n >> 8));
        pkt.push_back(8'(n));
        x = 8'(n >> 8) ^ 8'(n);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            for (int k = 3; k >= 0; k--) begin
                pkt.push_back(w[k*8 +: 8]);
                x = x ^ w[k*8 +: 8];
            end
            exp_addr.push_back(BASE + 32'(4 * (start + i)));
            exp_data.push_back(w);
        end
        pkt.push_back(bad_csum ? ~x : x);
    endtask

    task automatic mark();
        wr_base   = wr_q.size();
        done_base = done_n;
        rdy_base  = rdy_low_q.size();
    endtask

    task automatic check_result(input string tag, input bit exp_done);
        idle(3);
        check_eq({tag, "_nwr"}, 32'(wr_q.size() - wr_base), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && wr_base + i < wr_q.size(); i++) begin
            check_eq({tag, "_addr"}, wr_q[wr_base+i].addr, exp_addr[i]);
            check_eq({tag, "_data"}, wr_q[wr_base+i].data, exp_data[i]);
        end
        check_eq({tag, "_done"}, 32'(done_n - done_base), 32'(exp_done));
        check_eq({tag, "_err"}, 32'(bus.err), 32'(err_m));
        check_eq({tag, "_hold"}, 32'(bus.cpu_hold), 32'(hold_m));
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_we"}, 32'(bus.im_we), 32'd0);
        check_eq({tag, "_addr"}, bus.im_addr, 32'd0);
        check_eq({tag, "_wdata"}, bus.im_wdata, 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.rx_ready), 32'd1);
        check_eq({tag, "_hold"}, 32'(bus.cpu_hold), 32'd1);
    endtask

    initial begin
        logic [7:0] cmd;
        int         kind, n;
        bit         bad;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // Length overflow: N = 1121 on the main region.
        mark();
        pkt = '{8'h01, 8'h04, 8'h61};
        exp_addr.delete();
        exp_data.delete();
        send_range(0, 0);
        @(negedge clk);
        check_eq("ovf_err_now", 32'(bus.err), 32'd1);
        check_eq("ovf_busy_now", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        err_m = 1'b1;
        check_result("ovf", 1'b0);

        // Bad checksum on the two-word main packet: writes still land.
        mark();
        pkt = '{8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h30, 8'h00, 8'h11};
        exp_addr = '{32'h0000_3000, 32'h0000_3004};
        exp_data = '{32'hDEAD_BEEF, 32'h0000_3000};
        send_range(0, 0);
        err_m = 1'b1;
        check_result("badcsum", 1'b0);

        // Invalid command, then a handler packet that clears err on its command byte.
        mark();
        make_pkt(8'h02, 1, 1'b0);
        send_byte(8'h7F);
        @(negedge clk);
        check_eq("badcmd_err", 32'(bus.err), 32'd1);
        @(posedge clk);
        #1;
        send_byte(pkt[0]);
        @(negedge clk);
        check_eq("cmd_clears_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #1;
        send_range(1, 0);
        err_m = 1'b0;
        check_result("badcmd_then_h", 1'b1);

        // Handler load from the load procedure.
        mark();
        pkt = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        exp_addr = '{32'h0000_4180};
        exp_data = '{32'h0000_0000};
        send_range(0, 0);
        check_result("handler", 1'b1);

        // Main load, rx_valid held high: write timing, rx_ready gaps, done and hold release.
        mark();
        pkt = '{8'h01, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h30, 8'h00, 8'h10};
        exp_addr = '{32'h0000_3000, 32'h0000_3004};
        exp_data = '{32'hDEAD_BEEF, 32'h0000_3000};
        send_range(0, 0);
        @(negedge clk);
        check_eq("main_done_pulse", 32'(bus.done), 32'd1);
        check_eq("main_hold_at_done", 32'(bus.cpu_hold), 32'd1);
        @(negedge clk);
        check_eq("main_done_end", 32'(bus.done), 32'd0);
        check_eq("main_hold_after", 32'(bus.cpu_hold), 32'd0);
        @(posedge clk);
        #1;
        check_eq("main_rdy_low_n", 32'(rdy_low_q.size() - rdy_base), 32'd2);
        if (rdy_low_q.size() - rdy_base == 2 && wr_q.size() - wr_base == 2) begin
            check_eq("main_rdy_low_w0", 32'(rdy_low_q[rdy_base]), 32'(wr_q[wr_base].cyc));
            check_eq("main_rdy_low_w1", 32'(rdy_low_q[rdy_base+1]), 32'(wr_q[wr_base+1].cyc));
            check_eq("main_word_spacing", 32'(wr_q[wr_base+1].cyc - wr_q[wr_base].cyc), 32'd5);
        end
        hold_m = 1'b0;
        err_m  = 1'b0;
        check_result("main", 1'b1);

        // Reset after a partial word, with a byte offered on the reset edge.
        mark();
        exp_addr.delete();
        exp_data.delete();
        pkt = '{8'h01, 8'h00, 8'h01, 8'hAA, 8'hBB};
        send_range(0, 0);
        bus.rx_data  = 8'hCC;
        bus.rx_valid = 1'b1;
        reset        = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        hold_m = 1'b1;
        err_m  = 1'b0;
        check_result("midrst", 1'b0);
        mark();
        make_pkt(8'h01, 3, 1'b0);
        send_range(0, 0);
        hold_m = 1'b0;
        check_result("after_rst", 1'b1);

        // Region-capacity boundaries: both regions filled exactly.
        mark();
        make_pkt(8'h01, MAINW, 1'b0);
        send_range(0, 0);
        check_result("main_full", 1'b1);
        mark();
        make_pkt(8'h02, HW, 1'b0);
        send_range(0, 0);
        check_result("hdl_full", 1'b1);
        check_eq("hdl_last_addr", exp_addr[HW-1], 32'h0000_4FFC);
        mark();
        pkt = '{8'h02, 8'h03, 8'hA1};
        exp_addr.delete();
        exp_data.delete();
        send_range(0, 0);
        err_m = 1'b1;
        check_result("hdl_ovf", 1'b0);

        // Random packet mix with random inter-byte gaps.
        for (int t = 0; t < 40; t++) begin
            mark();
            kind = $urandom_range(0, 4);
            cmd  = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
            n    = $urandom_range(0, 5);
            bad  = (kind == 2);
            if (kind <= 2) begin
                make_pkt(cmd, n, bad);
                send_range(0, 3);
                err_m = bad;
                if (!bad && cmd == 8'h01) hold_m = 1'b0;
                check_result("rnd_pkt", !bad);
            end else if (kind == 3) begin
                n = ((cmd == 8'h01) ? MAINW : HW) + 1 + $urandom_range(0, 3000);
                pkt = '{cmd, 8'(n >> 8), 8'(n)};
                exp_addr.delete();
                exp_data.delete();
                send_range(0, 3);
                err_m = 1'b1;
                check_result("rnd_ovf", 1'b0);
            end else begin
                do cmd = 8'($urandom); while (cmd == 8'h01 || cmd == 8'h02);
                pkt = '{cmd};
                exp_addr.delete();
                exp_data.delete();
                send_range(0, 0);
                err_m = 1'b1;
                check_result("rnd_badcmd", 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
